// File: rtl/bus_xfer_sequencer.sv
// Register-transfer sequencer: queues {src, dst} code pairs and plays each out as a drive phase
// then a latch phase. Defining XFER_STATS_EN adds saturating transfer/error counters.
module bus_xfer_sequencer #(
   parameter int unsigned QDEPTH = 4,
   parameter int unsigned CODEW  = 5
) (
   input  logic                clk,
   input  logic                clr_n,
   input  logic                req_valid,
   input  logic [CODEW-1:0]    req_src,
   input  logic [CODEW-1:0]    req_dst,
   output logic                req_ready,
   output logic [2**CODEW-1:0] out_sel,
   output logic [2**CODEW-1:0] in_en,
   output logic                xfer_done,
   output logic                xfer_err,
`ifdef XFER_STATS_EN
   output logic [15:0]         xfer_count,
   output logic [15:0]         err_count,
`endif
   output logic                busy
);

   localparam int unsigned SELW   = 2**CODEW;
   localparam int unsigned NCODES = 24;
   localparam int unsigned PTRW   = $clog2(QDEPTH);
   localparam int unsigned CNTW   = PTRW + 1;

   typedef enum logic [1:0] {StIdle, StDrive, StLatch} state_t;

   state_t               state_q, state_d;
   logic [2*CODEW-1:0]   mem_q [QDEPTH];
   logic [PTRW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNTW-1:0]      count_q, count_d;
   logic [2*CODEW-1:0]   cur_q, cur_d;
   logic [2*CODEW-1:0]   head;
   logic [CODEW-1:0]     head_src;
   logic [CODEW-1:0]     cur_src, cur_dst;
   logic [SELW-1:0]      out_sel_q, out_sel_d;
   logic [SELW-1:0]      in_en_q, in_en_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 busy_q, busy_d;
   logic                 push, pop, empty, full;

   function automatic logic code_ok(input logic [CODEW-1:0] code);
      return 32'(code) < NCODES;
   endfunction

   function automatic logic [SELW-1:0] onehot(input logic [CODEW-1:0] code);
      logic [SELW-1:0] v;
      v = '0;
      if (code_ok(code)) v[code] = 1'b1;
      return v;
   endfunction

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNTW'(QDEPTH));
   assign req_ready = !full;
   assign push      = req_valid && req_ready;
   assign head      = mem_q[rd_ptr_q];
   assign head_src  = head[2*CODEW-1:CODEW];
   assign cur_src   = cur_q[2*CODEW-1:CODEW];
   assign cur_dst   = cur_q[CODEW-1:0];

   // Request queue; storage is not reset, only the pointers and count are.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {req_src, req_dst};
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Outputs are computed alongside the next state and registered with it.
   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      out_sel_d = out_sel_q;
      in_en_d   = '0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      pop       = 1'b0;
      case (state_q)
         StIdle: begin
            out_sel_d = '0;
            if (!empty) begin
               pop       = 1'b1;
               cur_d     = head;
               out_sel_d = onehot(head_src);
               state_d   = StDrive;
            end
         end
         StDrive: begin
            in_en_d = onehot(cur_dst);
            done_d  = 1'b1;
            err_d   = !code_ok(cur_src) || !code_ok(cur_dst);
            state_d = StLatch;
         end
         StLatch: begin
            if (!empty) begin
               pop       = 1'b1;
               cur_d     = head;
               out_sel_d = onehot(head_src);
               state_d   = StDrive;
            end else begin
               out_sel_d = '0;
               state_d   = StIdle;
            end
         end
         default: begin
            out_sel_d = '0;
            state_d   = StIdle;
         end
      endcase
   end

   assign busy_d = (state_d != StIdle) || (count_d != '0);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q   <= StIdle;
         cur_q     <= '0;
         out_sel_q <= '0;
         in_en_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         out_sel_q <= out_sel_d;
         in_en_q   <= in_en_d;
         done_q    <= done_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   assign out_sel   = out_sel_q;
   assign in_en     = in_en_q;
   assign xfer_done = done_q;
   assign xfer_err  = err_q;
   assign busy      = busy_q;

`ifdef XFER_STATS_EN
   logic [15:0] xfer_count_q, err_count_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         xfer_count_q <= '0;
         err_count_q  <= '0;
      end else begin
         if (done_q && xfer_count_q != 16'hFFFF) xfer_count_q <= xfer_count_q + 16'd1;
         if (err_q && err_count_q != 16'hFFFF)   err_count_q  <= err_count_q + 16'd1;
      end
   end

   assign xfer_count = xfer_count_q;
   assign err_count  = err_count_q;
`else
   // No statistics state in this build.
`endif

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Bench for bus_xfer_sequencer: table-driven single transfers, directed corner sequences and
// random traffic against a timeline model of accepted transfers.
module tb_bus_xfer_sequencer;

   localparam int unsigned QDEPTH = 4;

   logic        clk = 1'b0;
   logic        clr_n;
   logic        req_valid;
   logic [4:0]  req_src, req_dst;
   logic        req_ready, xfer_done, xfer_err, busy;
   logic [31:0] out_sel, in_en;
`ifdef XFER_STATS_EN
   logic [15:0] xfer_count, err_count;
`endif

   always #5 clk = ~clk;

   bus_xfer_sequencer #(.QDEPTH(QDEPTH), .CODEW(5)) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .req_valid  (req_valid),
      .req_src    (req_src),
      .req_dst    (req_dst),
      .req_ready  (req_ready),
      .out_sel    (out_sel),
      .in_en      (in_en),
      .xfer_done  (xfer_done),
      .xfer_err   (xfer_err),
`ifdef XFER_STATS_EN
      .xfer_count (xfer_count),
      .err_count  (err_count),
`endif
      .busy       (busy)
   );

   // Each accepted transfer: accept edge a, drive edge d (latch at d+1).
   typedef struct {
      int         a;
      int         d;
      logic [4:0] src;
      logic [4:0] dst;
   } xfer_t;

   typedef struct {
      logic [4:0]  src;
      logic [4:0]  dst;
      logic [31:0] exp_sel;
      logic [31:0] exp_en;
      logic        exp_err;
   } vec_t;

   xfer_t xq[$];
   int    edge_no   = 0;
   int    last_d    = -100;
   int    n_checks  = 0;
   int    n_fail    = 0;
   int    seen_done = 0;
   int    exp_xfers = 0;
   int    exp_errs  = 0;
   logic  last_acc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   function automatic logic [31:0] dec(input logic [4:0] c);
      logic [31:0] v;
      v = 32'd0;
      if (c < 5'd24) v = 32'd1 << c;
      return v;
   endfunction

   function automatic int model_count(input int e);
      int c;
      c = 0;
      foreach (xq[i]) if (xq[i].a <= e && xq[i].d > e) c++;
      return c;
   endfunction

   task automatic model_check();
      logic [31:0] e_sel, e_en;
      logic        e_done, e_err, e_busy;
      e_sel = 0; e_en = 0; e_done = 0; e_err = 0; e_busy = 0;
      foreach (xq[i]) begin
         if (xq[i].d == edge_no || xq[i].d + 1 == edge_no) e_sel = dec(xq[i].src);
         if (xq[i].d + 1 == edge_no) begin
            e_en   = dec(xq[i].dst);
            e_done = 1'b1;
            e_err  = (xq[i].src >= 5'd24) || (xq[i].dst >= 5'd24);
         end
         if (xq[i].a <= edge_no && edge_no < xq[i].d + 2) e_busy = 1'b1;
      end
      check("out_sel", out_sel, e_sel);
      check("in_en", in_en, e_en);
      check("xfer_done", xfer_done, e_done);
      check("xfer_err", xfer_err, e_err);
      check("busy", busy, e_busy);
      check("req_ready", req_ready, model_count(edge_no) < QDEPTH);
      if (e_done) exp_xfers++;
      if (e_err) exp_errs++;
      while (xq.size() > 0 && xq[0].d + 2 < edge_no) void'(xq.pop_front());
   endtask

   // One clock: drive at negedge, edge, compare at the following negedge.
   task automatic step(input logic v, input logic [4:0] s, input logic [4:0] d);
      xfer_t t;
      req_valid = v;
      req_src   = s;
      req_dst   = d;
      last_acc  = v && (model_count(edge_no) < QDEPTH);
      @(posedge clk);
      edge_no++;
      if (last_acc) begin
         t.a   = edge_no;
         t.d   = (edge_no + 1 > last_d + 2) ? edge_no + 1 : last_d + 2;
         t.src = s;
         t.dst = d;
         last_d = t.d;
         xq.push_back(t);
      end
      @(negedge clk);
      model_check();
      if (xfer_done === 1'b1) seen_done++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0);
   endtask

   task automatic apply_reset();
      clr_n     = 1'b0;
      req_valid = 1'b1;
      req_src   = 5'd3;
      req_dst   = 5'd7;
      xq.delete();
      last_d    = -100;
      exp_xfers = 0;
      exp_errs  = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         edge_no++;
         @(negedge clk);
         check("rst_out_sel", out_sel, 32'd0);
         check("rst_in_en", in_en, 32'd0);
         check("rst_done", {xfer_done, xfer_err}, 32'd0);
         check("rst_busy", busy, 32'd0);
         check("rst_ready", req_ready, 32'd1);
      end
      clr_n     = 1'b1;
      req_valid = 1'b0;
   endtask

   vec_t tbl[7];
   int   d0, acc_n;
   logic saw_block;

   initial begin
      tbl[0] = '{5'd3,  5'd7,  32'h0000_0008, 32'h0000_0080, 1'b0};
      tbl[1] = '{5'd25, 5'd4,  32'h0000_0000, 32'h0000_0010, 1'b1};
      tbl[2] = '{5'd1,  5'd30, 32'h0000_0002, 32'h0000_0000, 1'b1};
      tbl[3] = '{5'd20, 5'd21, 32'h0010_0000, 32'h0020_0000, 1'b0};
      tbl[4] = '{5'd23, 5'd0,  32'h0080_0000, 32'h0000_0001, 1'b0};
      tbl[5] = '{5'd24, 5'd23, 32'h0000_0000, 32'h0080_0000, 1'b1};
      tbl[6] = '{5'd0,  5'd31, 32'h0000_0001, 32'h0000_0000, 1'b1};

      apply_reset();
      idle(2);

      // Single transfers from idle.
      for (int i = 0; i < 7; i++) begin
         step(1'b1, tbl[i].src, tbl[i].dst);
         step(1'b0, 5'd0, 5'd0);
         check("tbl_drive_sel", out_sel, tbl[i].exp_sel);
         check("tbl_drive_en", in_en, 32'd0);
         step(1'b0, 5'd0, 5'd0);
         check("tbl_latch_sel", out_sel, tbl[i].exp_sel);
         check("tbl_latch_en", in_en, tbl[i].exp_en);
         check("tbl_latch_done", xfer_done, 32'd1);
         check("tbl_latch_err", xfer_err, tbl[i].exp_err);
         step(1'b0, 5'd0, 5'd0);
         check("tbl_after_sel", out_sel, 32'd0);
         check("tbl_after_busy", busy, 32'd0);
      end

      // Back-to-back: four pushes, no IDLE gap, four done pulses.
      d0 = seen_done;
      step(1'b1, 5'd2, 5'd5);
      step(1'b1, 5'd20, 5'd21);
      step(1'b1, 5'd18, 5'd16);
      step(1'b1, 5'd21, 5'd22);
      idle(10);
      check("b2b_done_count", seen_done - d0, 4);

      // Full queue: keep pushing until ready drops, then drain.
      d0 = seen_done;
      acc_n = 0;
      saw_block = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (req_ready === 1'b0) saw_block = 1'b1;
         step(1'b1, 5'(i + 8), 5'(15 - i));
         if (last_acc) acc_n++;
      end
      idle(16);
      check("full_ready_dropped", saw_block, 1);
      check("full_done_count", seen_done - d0, acc_n);

      // Reset during the latch of the second of three transfers.
      d0 = seen_done;
      step(1'b1, 5'd4, 5'd9);
      step(1'b1, 5'd6, 5'd11);
      step(1'b1, 5'd8, 5'd13);
      step(1'b0, 5'd0, 5'd0);
      step(1'b0, 5'd0, 5'd0);
      check("midrst_in_latch", in_en, 32'h0000_0800);
      #2 clr_n = 1'b0;
      #1;
      check("midrst_out_sel", out_sel, 32'd0);
      check("midrst_in_en", in_en, 32'd0);
      check("midrst_done", xfer_done, 32'd0);
      check("midrst_busy", busy, 32'd0);
      xq.delete();
      last_d = -100;
      exp_xfers = 0;
      exp_errs  = 0;
      @(posedge clk);
      edge_no++;
      @(negedge clk);
      clr_n = 1'b1;
      d0 = seen_done;
      idle(8);
      check("midrst_no_done", seen_done - d0, 0);

      // Random traffic, biased to overrun the queue.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
      idle(14);

`ifdef XFER_STATS_EN
      check("stats_rand_xfer", xfer_count, exp_xfers);
      check("stats_rand_err", err_count, exp_errs);
      apply_reset();
      check("stats_rst_xfer", xfer_count, 0);
      step(1'b1, 5'd1, 5'd2);
      step(1'b1, 5'd26, 5'd3);
      step(1'b1, 5'd5, 5'd6);
      step(1'b1, 5'd7, 5'd29);
      step(1'b1, 5'd9, 5'd10);
      idle(12);
      check("stats_xfer_count", xfer_count, 16'd5);
      check("stats_err_count", err_count, 16'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
